// File: rtl/subt_seq_ctrl_if.sv
// Operand/result bundle for the multi-precision subtract sequencer.
// master drives the request side; slave is the sequencer itself.
interface subt_seq_ctrl_if #(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned NWORDS = 4
);
    localparam int unsigned TOT_W = WORD_W * NWORDS;

    logic             startIn;
    logic [TOT_W-1:0] aIn;
    logic [TOT_W-1:0] bIn;
    logic             crIn;
    logic             readyOut;
    logic             busyOut;
    logic             doneOut;
    logic [TOT_W-1:0] diffOut;
    logic             brw;
    logic             zeroOut;

    modport master (
        output startIn, aIn, bIn, crIn,
        input  readyOut, busyOut, doneOut, diffOut, brw, zeroOut
    );

    modport slave (
        input  startIn, aIn, bIn, crIn,
        output readyOut, busyOut, doneOut, diffOut, brw, zeroOut
    );
endinterface

// File: rtl/subt_seq_ctrl.sv
// Multi-precision subtract sequencer: one WORD_W-bit full-subtractor slice
// reused over NWORDS words, LSW first, with a registered borrow chain.
module subt_seq_ctrl #(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned NWORDS = 4
) (
    input logic           clk,
    input logic           rst,
    subt_seq_ctrl_if.slave bus
);
    localparam int unsigned TOT_W = WORD_W * NWORDS;
    localparam int unsigned KW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

    stateT            state, stateNext;
    logic [KW-1:0]    k, kNext;
    logic             borrow, borrowNext;
    logic [TOT_W-1:0] opA, opANext, opB, opBNext;
    logic [TOT_W-1:0] diffQ, diffNext;
    logic             brwQ, brwNext, zeroQ, zeroNext;
    logic             readyQ, readyNext, busyQ, busyNext, doneQ, doneNext;

    logic [WORD_W-1:0] sliceA, sliceB, sliceD;
    logic              sliceBo, ripple;

    // Shared full-subtractor slice on word k, bitwise ripple borrow
    always_comb begin
        sliceA = opA[int'(k) * WORD_W +: WORD_W];
        sliceB = opB[int'(k) * WORD_W +: WORD_W];
        sliceD = '0;
        ripple = borrow;
        for (int i = 0; i < int'(WORD_W); i++) begin
            sliceD[i] = sliceA[i] ^ sliceB[i] ^ ripple;
            ripple    = (~sliceA[i] & sliceB[i]) | (~sliceA[i] & ripple) | (sliceB[i] & ripple);
        end
        sliceBo = ripple;
    end

    // Next-state and registered-output logic
    always_comb begin
        stateNext  = state;
        kNext      = k;
        borrowNext = borrow;
        opANext    = opA;
        opBNext    = opB;
        diffNext   = diffQ;
        brwNext    = brwQ;
        zeroNext   = zeroQ;
        doneNext   = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (bus.startIn) begin
                    opANext    = bus.aIn;
                    opBNext    = bus.bIn;
                    borrowNext = bus.crIn;
                    kNext      = '0;
                    stateNext  = RUN;
                end
            end
            RUN: begin
                diffNext[int'(k) * WORD_W +: WORD_W] = sliceD;
                borrowNext = sliceBo;
                if (k == K_LAST) begin
                    stateNext = DONE;
                    doneNext  = 1'b1;
                    brwNext   = sliceBo;
                    zeroNext  = (diffNext == '0);
                end else begin
                    kNext = k + KW'(1);
                end
            end
            default: stateNext = IDLE;
        endcase

        readyNext = (stateNext != RUN);
        busyNext  = (stateNext == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            k      <= '0;
            borrow <= 1'b0;
            opA    <= '0;
            opB    <= '0;
            diffQ  <= '0;
            brwQ   <= 1'b0;
            zeroQ  <= 1'b0;
            readyQ <= 1'b1;
            busyQ  <= 1'b0;
            doneQ  <= 1'b0;
        end else begin
            state  <= stateNext;
            k      <= kNext;
            borrow <= borrowNext;
            opA    <= opANext;
            opB    <= opBNext;
            diffQ  <= diffNext;
            brwQ   <= brwNext;
            zeroQ  <= zeroNext;
            readyQ <= readyNext;
            busyQ  <= busyNext;
            doneQ  <= doneNext;
        end
    end

    assign bus.readyOut = readyQ;
    assign bus.busyOut  = busyQ;
    assign bus.doneOut  = doneQ;
    assign bus.diffOut  = diffQ;
    assign bus.brw      = brwQ;
    assign bus.zeroOut  = zeroQ;
endmodule

// File: tb/tb_subt_seq_ctrl.sv
// Self-checking bench for subt_seq_ctrl: directed vectors, corner sequences
// and randomised operations against a plain-arithmetic reference.
module tb_subt_seq_ctrl;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned NWORDS = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    subt_seq_ctrl_if #(.WORD_W(WORD_W), .NWORDS(NWORDS)) bus ();
    subt_seq_ctrl #(.WORD_W(WORD_W), .NWORDS(NWORDS)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cr;
        logic [63:0] d;
        logic        bo;
        logic        z;
    } vecT;

    vecT vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input string field, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s: got %h expected %h", tag, field, act, exp);
        end
    endtask

    // Reference: unsigned 64-bit arithmetic straight from the operation definition
    function automatic void refModel(input logic [63:0] a, input logic [63:0] b, input logic cr,
                                     output logic [63:0] d, output logic bo, output logic z);
        logic [64:0] rhs;
        rhs = {1'b0, b} + 65'(cr);
        d   = a - b - 64'(cr);
        bo  = ({1'b0, a} < rhs);
        z   = (d == 64'd0);
    endfunction

    // chain: finish in the doneOut cycle; hammer: hold startIn with junk operands during RUN
    task automatic runOp(input string tag, input logic [63:0] a, input logic [63:0] b, input logic cr,
                         input logic [63:0] expD, input logic expB, input logic expZ,
                         input bit chain, input bit hammer);
        int n;
        int busyCnt;
        int guard;
        guard = 0;
        while (!bus.readyOut && guard < 20) begin
            tick();
            guard++;
        end
        chk(tag, "ready", 64'(bus.readyOut), 64'd1);
        bus.startIn = 1'b1;
        bus.aIn     = a;
        bus.bIn     = b;
        bus.crIn    = cr;
        tick();
        bus.startIn = 1'b0;
        bus.aIn     = ~a;
        bus.bIn     = {$urandom, $urandom};
        bus.crIn    = ~cr;
        chk(tag, "busyAfterAccept", 64'(bus.busyOut), 64'd1);
        n       = 0;
        busyCnt = 0;
        while (!bus.doneOut && n < 20) begin
            if (bus.busyOut) busyCnt++;
            if (hammer) begin
                bus.startIn = 1'b1;
                bus.aIn     = {$urandom, $urandom};
                bus.bIn     = {$urandom, $urandom};
                bus.crIn    = 1'($urandom);
            end
            tick();
            n++;
        end
        bus.startIn = 1'b0;
        chk(tag, "latency", 64'(n), 64'(NWORDS));
        chk(tag, "busyCycles", 64'(busyCnt), 64'(NWORDS));
        chk(tag, "diff", bus.diffOut, expD);
        chk(tag, "brw", 64'(bus.brw), 64'(expB));
        chk(tag, "zero", 64'(bus.zeroOut), 64'(expZ));
        chk(tag, "readyAtDone", 64'(bus.readyOut), 64'd1);
        if (!chain) begin
            tick();
            chk(tag, "donePulse", 64'(bus.doneOut), 64'd0);
            chk(tag, "diffHeld", bus.diffOut, expD);
            chk(tag, "brwHeld", 64'(bus.brw), 64'(expB));
        end
    endtask

    task automatic chkReset(input string tag);
        chk(tag, "ready", 64'(bus.readyOut), 64'd1);
        chk(tag, "busy", 64'(bus.busyOut), 64'd0);
        chk(tag, "done", 64'(bus.doneOut), 64'd0);
        chk(tag, "diff", bus.diffOut, 64'd0);
        chk(tag, "brw", 64'(bus.brw), 64'd0);
        chk(tag, "zero", 64'(bus.zeroOut), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] a, b, d;
        logic        cr, bo, z;
        int          t1, t2, sawDone;

        vecs[0] = '{64'h0000_0001_0000_0000, 64'h1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0};
        vecs[1] = '{64'h0, 64'h1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vecs[2] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vecs[3] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'h0, 1'b0, 1'b1};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[5] = '{64'h5, 64'h3, 1'b1, 64'h1, 1'b0, 1'b0};
        vecs[6] = '{64'h0, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};

        rst         = 1'b1;
        bus.startIn = 1'b0;
        bus.aIn     = '0;
        bus.bIn     = '0;
        bus.crIn    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        chkReset("reset");

        foreach (vecs[i])
            runOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cr,
                  vecs[i].d, vecs[i].bo, vecs[i].z, 1'b0, 1'b0);

        // startIn held through RUN with changing operands: only the first op runs
        runOp("hammer", 64'hDEAD_BEEF_0000_0000, 64'h0000_0000_0000_0001, 1'b1,
              64'hDEAD_BEEE_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back: second start issued in the doneOut cycle
        runOp("b2b0", 64'h0000_0000_0001_0000, 64'h0000_0000_0000_0001, 1'b0,
              64'h0000_0000_0000_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        t1 = cyc;
        runOp("b2b1", 64'h1, 64'h8000_0000_0000_0000, 1'b0,
              64'h8000_0000_0000_0001, 1'b1, 1'b0, 1'b1, 1'b0);
        t2 = cyc;
        chk("b2b", "gap", 64'(t2 - t1), 64'(NWORDS + 1));
        tick();

        // Reset in the middle of RUN (word index 2)
        bus.startIn = 1'b1;
        bus.aIn     = 64'h0123_4567_89AB_CDEF;
        bus.bIn     = 64'h0FED_CBA9_8765_4321;
        bus.crIn    = 1'b0;
        tick();
        bus.startIn = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chkReset("midReset");
        sawDone = 0;
        for (int i = 0; i < int'(NWORDS) + 2; i++) begin
            if (bus.doneOut || bus.busyOut) sawDone++;
            tick();
        end
        chk("midReset", "noDone", 64'(sawDone), 64'd0);
        runOp("afterReset", 64'h0123_4567_89AB_CDEF, 64'h0FED_CBA9_8765_4321, 1'b0,
              64'hF135_79BE_0246_8ACE, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset wins over a same-cycle start
        rst         = 1'b1;
        bus.startIn = 1'b1;
        tick();
        rst         = 1'b0;
        bus.startIn = 1'b0;
        chkReset("rstStart");
        tick();
        chk("rstStart", "stillIdle", 64'(bus.busyOut), 64'd0);

        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 3))
                0: begin a = {$urandom, $urandom}; b = a; end
                1: begin a = 64'($urandom_range(0, 3)); b = {$urandom, $urandom}; end
                default: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
            endcase
            cr = 1'($urandom);
            refModel(a, b, cr, d, bo, z);
            runOp($sformatf("rnd%0d", i), a, b, cr, d, bo, z, 1'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
